// File: rtl/tqvp_nkanderson_wdt_pkg.sv
// Shared types and defaults for the TinyQV watchdog core and its register wrapper.
// The numeric state constants match the encoding the wrapper exposes on read-back.
package tqvp_nkanderson_wdt_pkg;

  localparam int WDT_WIDTH     = 32;
  localparam int WDT_RST_PULSE = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_WARNED = 2'd2,
    ST_BITE   = 2'd3
  } wdt_state_e;

  localparam logic [1:0] WDT_ST_IDLE   = 2'd0;
  localparam logic [1:0] WDT_ST_ARMED  = 2'd1;
  localparam logic [1:0] WDT_ST_WARNED = 2'd2;
  localparam logic [1:0] WDT_ST_BITE   = 2'd3;

endpackage

// File: rtl/wdt_pulse_stretch.sv
// Turns a one-cycle fire strobe into a registered pulse exactly RST_PULSE cycles wide.
// done is high during the last pulse cycle, so the FSM leaves BITE on the edge the pulse drops.
module wdt_pulse_stretch #(
  parameter int RST_PULSE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fire,
  output logic pulse,
  output logic done
);

  localparam int CW = $clog2(RST_PULSE + 1);

  logic [CW-1:0] cnt_q;
  logic          pulse_q;

  // cnt_q holds the number of pulse cycles still to follow the current one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else if (fire && !pulse_q) begin
      cnt_q   <= CW'(RST_PULSE - 1);
      pulse_q <= 1'b1;
    end else if (pulse_q) begin
      if (cnt_q == '0) begin
        pulse_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  assign pulse = pulse_q;
  assign done  = pulse_q && (cnt_q == '0);

endmodule

// File: rtl/tqvp_nkanderson_wdt_core.sv
// Two-stage watchdog countdown: first expiry raises a sticky irq, a second
// unserviced expiry issues a fixed-width reset pulse. All outputs registered.
module tqvp_nkanderson_wdt_core
  import tqvp_nkanderson_wdt_pkg::*;
#(
  parameter int WIDTH     = WDT_WIDTH,
  parameter int RST_PULSE = WDT_RST_PULSE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_load,
  input  logic [WIDTH-1:0] cfg_timeout,
  input  logic             start,
  input  logic             stop,
  input  logic             kick,
  input  logic             irq_clear,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             irq,
  output logic             wdt_rst
);

  wdt_state_e       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] timeout_q;
  logic             irq_q;
  logic             irq_set;
  logic             fire;
  logic             bite_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      timeout_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (cfg_load) begin
        timeout_q <= cfg_timeout;
      end
      // a set in the same cycle as a clear wins
      if (irq_set) begin
        irq_q <= 1'b1;
      end else if (irq_clear) begin
        irq_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    irq_set = 1'b0;
    fire    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && (timeout_q != '0)) begin
          state_d = ST_ARMED;
          count_d = timeout_q;
        end
      end
      ST_ARMED, ST_WARNED: begin
        if (stop) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (kick || start) begin
          state_d = ST_ARMED;
          count_d = timeout_q;
        end else if (count_q == '0) begin
          if (state_q == ST_ARMED) begin
            state_d = ST_WARNED;
            count_d = timeout_q;
            irq_set = 1'b1;
          end else begin
            state_d = ST_BITE;
            count_d = '0;
            fire    = 1'b1;
          end
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
      ST_BITE: begin
        count_d = '0;
        if (bite_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  wdt_pulse_stretch #(
    .RST_PULSE(RST_PULSE)
  ) u_pulse (
    .clk  (clk),
    .rst_n(rst_n),
    .fire (fire),
    .pulse(wdt_rst),
    .done (bite_done)
  );

  assign count = count_q;
  assign state = state_q;
  assign irq   = irq_q;

endmodule

// File: doc/tqvp_nkanderson_wdt_core.md
# tqvp_nkanderson_wdt_core

Countdown engine of the TinyQV watchdog peripheral, directly downstream of the `tqvp_nkanderson_wdt` bus/register wrapper. It consumes decoded register strobes (load timeout, start, stop, kick, interrupt clear) and runs a two-stage watchdog. The first expiry raises an interrupt. A second expiry with no kick in between issues a fixed-width reset pulse. Its status outputs feed the wrapper's read-back mux and its `user_interrupt`.

## Interface
- `WIDTH`, 32: counter and timeout width in bits.
- `RST_PULSE`, 16: width of the `wdt_rst` pulse in cycles, must be ≥1.
- `clk` in 1: peripheral clock, 64 MHz nominal.
- `rst_n` in 1: reset; one clock, reset asynchronous and active-low.
- `cfg_load` in 1: single-cycle strobe, latch `cfg_timeout` into `timeout_q`.
- `cfg_timeout` in WIDTH: timeout value in cycles, sampled with `cfg_load`.
- `start` in 1: strobe, arm the watchdog.
- `stop` in 1: strobe, disarm the watchdog.
- `kick` in 1: strobe, service (reload) the watchdog.
- `irq_clear` in 1: strobe, clear `irq`.
- `count` out WIDTH: current down-counter value.
- `state` out 2: 0 IDLE, 1 ARMED, 2 WARNED, 3 BITE.
- `irq` out 1: sticky expiry interrupt, level.
- `wdt_rst` out 1: reset request pulse.

## Operation
- Reset values: `timeout_q`=0, `count`=0, `state`=IDLE, `irq`=0, `wdt_rst`=0. Reset mid-operation (any state, including mid-pulse) returns everything to these values immediately.
- `cfg_load`: `timeout_q` <= `cfg_timeout` in any state. It does not touch `count`. A new value applies only at the next reload.
- IDLE:
  - `start` with `timeout_q`≠0 → ARMED, `count` <= `timeout_q`.
  - `start` with `timeout_q`=0 is ignored and the block stays in IDLE.
  - `kick` and `stop` are ignored.
- ARMED:
  - `count` decrements by 1 per cycle.
  - At `count`=0 with no kick/stop: → WARNED, `irq` <= 1, `count` <= `timeout_q`.
- WARNED:
  - `count` decrements by 1 per cycle.
  - `kick` → ARMED with reload. `irq` is unaffected.
  - At `count`=0 with no kick/stop: → BITE, `count` <= 0, `wdt_rst` <= 1.
- Reload rule: `kick` or `start` in ARMED/WARNED → ARMED, `count` <= `timeout_q`.
- `stop` in ARMED/WARNED → IDLE, `count` <= 0. `irq` is unaffected.
- BITE:
  - `wdt_rst` stays high for exactly RST_PULSE cycles, then → IDLE, `wdt_rst` <= 0.
  - `start`, `stop`, `kick` and `cfg_load` side effects on state are ignored. `cfg_load` still updates `timeout_q`.
- Priority within one cycle: `stop` > `kick`/`start` > expiry.
- `irq`:
  - Set by the ARMED→WARNED transition.
  - Cleared by `irq_clear`.
  - When set and clear happen in the same cycle, set wins.
- The counter never wraps. In ARMED/WARNED the value 0 always causes a transition instead of a decrement.

## Timing
- All outputs are registered. The effect of a strobe is visible the cycle after it is sampled.
- ARMED→WARNED: the transition happens `timeout_q`+1 cycles after the `start` edge (count T..0 inclusive). WARNED→BITE takes another `timeout_q`+1 cycles.
- Minimum `timeout_q`=1 gives 2 cycles per stage.
- `wdt_rst` rises on the same edge `state` becomes BITE. It falls on the edge `state` becomes IDLE.
- Strobes are single-cycle. A held strobe acts every cycle; e.g. a held `kick` keeps `count` at `timeout_q`.

## Structure
- Package `tqvp_nkanderson_wdt_pkg` holds:
  - `wdt_state_e` (IDLE/ARMED/WARNED/BITE, 2-bit);
  - `WDT_WIDTH` default;
  - `WDT_RST_PULSE` default;
  - the state-encoding constants used by the wrapper read-back.
- Sub-module `wdt_pulse_stretch`: a $clog2(RST_PULSE+1)-bit counter that generates `wdt_rst` from a one-cycle fire strobe and returns a done strobe to the FSM.
- The core holds the FSM, `timeout_q`, `count` and `irq`.

## Test plan
- Load `cfg_timeout`=5, `start`:
  - `state`=ARMED and `count`=5 one cycle later.
  - `irq` rises 6 cycles after that with `count`=5, `state`=WARNED.
  - 6 cycles later `state`=BITE and `wdt_rst`=1 for exactly 16 cycles, then IDLE, `count`=0.
- Timeout 5, `kick` every 4 cycles for 100 cycles: `irq` and `wdt_rst` stay 0 and `count` never goes below 1.
- Simultaneous events:
  - `kick` on the cycle `count`=0 in ARMED → ARMED, `count`=5, no `irq`.
  - `stop`+`kick` together → IDLE.
  - `irq_clear` on the `irq`-set cycle → `irq`=1.
- `start` with `timeout_q`=0 → stays IDLE. `cfg_load`=3 while ARMED at `count`=4 → counts to 0, then reloads to 3 on entering WARNED.
- Deassert `rst_n` asynchronously mid-BITE (cycle 7 of the pulse) → `wdt_rst`, `irq`, `count` and `state` are 0 with no clock edge. After release, `start` with timeout 0 stays IDLE.
